// File: rtl/lreport_gen.sv
// rtl/lreport_gen.sv - beacon-report injector on the 134-bit UM packet stream
// Forwards upstream packets with one cycle of latency and inserts counter reports between packets.
module lreport_gen #(
   parameter int          NUM_CNT    = 6,
   parameter int          PERIOD_BIT = 30,
   parameter logic [7:0]  SMID       = 8'd128,
   parameter logic [7:0]  DMID       = 8'd1,
   parameter logic [47:0] DST_MAC    = 48'h010203040506,
   parameter logic [15:0] ETHERTYPE  = 16'h88f7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_data_wr,
   input  logic [133:0]          in_data,
   input  logic                  in_data_valid,
   input  logic                  in_data_valid_wr,
   output logic                  pktin_ready,
   input  logic [47:0]           precision_time,
   input  logic [47:0]           local_mac,
   input  logic                  report_en,
   input  logic                  sw_trigger,
   input  logic                  update_toggle,
   input  logic [NUM_CNT*64-1:0] cnt_in,
   output logic                  out_data_wr,
   output logic [133:0]          out_data,
   output logic                  out_data_valid,
   output logic                  out_data_valid_wr,
   output logic [15:0]           report_seq,
   output logic [15:0]           overrun_cnt,
   output logic [15:0]           protocol_err_cnt
);

   localparam int          NW       = (NUM_CNT + 1) / 2;
   localparam int          W        = 2 + NW;
   localparam logic [15:0] PKT_LEN  = 16'(16 * W);
   localparam logic [3:0]  LAST_IDX = 4'(W);

   typedef enum logic [1:0] {IDLE, PASS, REPORT, GAP} state_t;

   state_t                  state, state_n;
   logic [3:0]              idx, idx_n;
   logic                    pending, zero_prev, update_seen;
   logic [NUM_CNT*64-1:0]   cnt_snap;
   logic [47:0]             ts_snap;
   logic                    out_wr_n, out_valid_n, out_valid_wr_n, rdy_n;
   logic [133:0]            out_data_n, rpt_word;
   logic                    upd_load, seq_inc, perr;
   logic                    zero_now, tick, trig, pending_clr, upd;
   logic [3:0]              pair_k;
   logic [127:0]            pair_w [16];

   assign zero_now    = (precision_time[PERIOD_BIT-1:0] == '0);
   assign tick        = zero_now & ~zero_prev;
   assign trig        = report_en & (tick | sw_trigger);
   // A pending report is consumed only in an IDLE cycle with no word arriving.
   assign pending_clr = (state == IDLE) & ~in_data_wr & pending;
   assign upd         = update_toggle ^ update_seen;
   assign pair_k      = idx - 4'd3;

   // Counter pairs, high lane = even counter; lanes past NUM_CNT read as zero.
   for (genvar g = 0; g < 16; g++) begin : g_pair
      if (2 * g + 1 < NUM_CNT) begin : g_full
         assign pair_w[g] = {cnt_snap[128*g +: 64], cnt_snap[128*g+64 +: 64]};
      end else if (2 * g < NUM_CNT) begin : g_half
         assign pair_w[g] = {cnt_snap[128*g +: 64], 64'b0};
      end else begin : g_none
         assign pair_w[g] = '0;
      end
   end

   always_comb begin
      rpt_word = '0;
      case (idx)
         4'd0:    rpt_word = {2'b01, 4'b0, 1'b1, 15'b0, PKT_LEN, SMID, DMID, 80'b0};
         4'd1:    rpt_word = {2'b11, 4'b0, DST_MAC, local_mac, ETHERTYPE, 3'b0, upd, 12'b0};
         4'd2:    rpt_word = {2'b11, 4'b0, report_seq, 48'b0, ts_snap, 16'b0};
         default: rpt_word = {(idx == LAST_IDX) ? 2'b10 : 2'b11, 4'b0, pair_w[pair_k]};
      endcase
   end

   always_comb begin
      state_n        = state;
      idx_n          = idx;
      out_wr_n       = 1'b0;
      out_data_n     = '0;
      out_valid_n    = 1'b0;
      out_valid_wr_n = 1'b0;
      rdy_n          = pktin_ready;
      upd_load       = 1'b0;
      seq_inc        = 1'b0;
      perr           = 1'b0;
      case (state)
         IDLE: begin
            if (in_data_wr) begin
               out_wr_n       = 1'b1;
               out_data_n     = in_data;
               out_valid_n    = in_data_valid;
               out_valid_wr_n = in_data_valid_wr;
               if (in_data[133:132] != 2'b10) state_n = PASS;
            end else if (pending) begin
               rdy_n   = 1'b0;
               idx_n   = 4'd0;
               state_n = REPORT;
            end
         end
         PASS: begin
            out_wr_n       = in_data_wr;
            out_data_n     = in_data;
            out_valid_n    = in_data_valid;
            out_valid_wr_n = in_data_valid_wr;
            if (in_data_wr && in_data[133:132] == 2'b10) state_n = IDLE;
         end
         REPORT: begin
            perr       = in_data_wr;
            out_wr_n   = 1'b1;
            out_data_n = rpt_word;
            upd_load   = (idx == 4'd1);
            if (idx == LAST_IDX) begin
               out_valid_n    = 1'b1;
               out_valid_wr_n = 1'b1;
               seq_inc        = 1'b1;
               state_n        = GAP;
            end else begin
               idx_n = idx + 4'd1;
            end
         end
         default: begin
            perr    = in_data_wr;
            rdy_n   = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= IDLE;
         idx               <= '0;
         pending           <= 1'b0;
         zero_prev         <= 1'b0;
         update_seen       <= 1'b0;
         cnt_snap          <= '0;
         ts_snap           <= '0;
         pktin_ready       <= 1'b1;
         out_data_wr       <= 1'b0;
         out_data          <= '0;
         out_data_valid    <= 1'b0;
         out_data_valid_wr <= 1'b0;
         report_seq        <= '0;
         overrun_cnt       <= '0;
         protocol_err_cnt  <= '0;
      end else begin
         state             <= state_n;
         idx               <= idx_n;
         zero_prev         <= zero_now;
         pktin_ready       <= rdy_n;
         out_data_wr       <= out_wr_n;
         out_data          <= out_data_n;
         out_data_valid    <= out_valid_n;
         out_data_valid_wr <= out_valid_wr_n;
         if (trig) pending <= 1'b1;
         else if (pending_clr) pending <= 1'b0;
         // A trigger landing as the pending one is consumed queues a fresh report, not an overrun.
         if (trig && pending && !pending_clr && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
         if (pending_clr) begin
            cnt_snap <= cnt_in;
            ts_snap  <= precision_time;
         end
         if (upd_load) update_seen <= update_toggle;
         if (seq_inc) report_seq <= report_seq + 16'd1;
         if (perr && protocol_err_cnt != 16'hFFFF)
            protocol_err_cnt <= protocol_err_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_lreport_gen.sv
// tb/tb_lreport_gen.sv - directed bench for lreport_gen with NUM_CNT=3
module tb_lreport_gen;

   localparam logic [63:0]  C0  = 64'h1111_2222_3333_4444;
   localparam logic [63:0]  C1  = 64'h5555_6666_7777_8888;
   localparam logic [63:0]  C2  = 64'h9999_AAAA_BBBB_CCCC;
   localparam logic [191:0] ALT = {64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
   localparam logic [47:0]  MAC = 48'hA0B1_C2D3_E4F5;
   localparam logic [47:0]  T0  = 48'h1234_5678_9ABC;

   logic         clk = 1'b0;
   logic         rst, in_data_wr, in_data_valid, in_data_valid_wr, pktin_ready;
   logic [133:0] in_data, out_data;
   logic [47:0]  precision_time, local_mac;
   logic         report_en, sw_trigger, update_toggle;
   logic [191:0] cnt_in;
   logic         out_data_wr, out_data_valid, out_data_valid_wr;
   logic [15:0]  report_seq, overrun_cnt, protocol_err_cnt;

   int n_chk = 0;
   int n_fail = 0;
   logic [15:0] exp_seq = 16'd0;

   always #5 clk = ~clk;

   lreport_gen #(.NUM_CNT(3)) dut (
      .clk(clk), .rst(rst), .in_data_wr(in_data_wr), .in_data(in_data),
      .in_data_valid(in_data_valid), .in_data_valid_wr(in_data_valid_wr),
      .pktin_ready(pktin_ready), .precision_time(precision_time), .local_mac(local_mac),
      .report_en(report_en), .sw_trigger(sw_trigger), .update_toggle(update_toggle),
      .cnt_in(cnt_in), .out_data_wr(out_data_wr), .out_data(out_data),
      .out_data_valid(out_data_valid), .out_data_valid_wr(out_data_valid_wr),
      .report_seq(report_seq), .overrun_cnt(overrun_cnt), .protocol_err_cnt(protocol_err_cnt)
   );

   typedef struct {
      logic         sw;
      logic         alt;
      logic         e_wr;
      logic [133:0] e_data;
      logic         e_vwr;
      logic         e_rdy;
   } vec_t;

   vec_t tv[9];

   function automatic logic [133:0] w0();
      return {2'b01, 4'b0, 1'b1, 15'b0, 16'd64, 8'h80, 8'h01, 80'b0};
   endfunction
   function automatic logic [133:0] w1(input logic u);
      return {2'b11, 4'b0, 48'h010203040506, MAC, 16'h88F7, 3'b0, u, 12'b0};
   endfunction
   function automatic logic [133:0] w2(input logic [15:0] s, input logic [47:0] t);
      return {2'b11, 4'b0, s, 48'b0, t, 16'b0};
   endfunction
   function automatic logic [133:0] w3();
      return {2'b11, 4'b0, C0, C1};
   endfunction
   function automatic logic [133:0] w4();
      return {2'b10, 4'b0, C2, 64'b0};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Checks the five report words and the gap cycle; the report has already started.
   task automatic report_body(input logic exp_upd, input int inj, input logic [47:0] t, input string tag);
      logic [133:0] e;
      for (int k = 0; k < 5; k++) begin
         if (k == inj) begin
            in_data_wr = 1'b1;
            in_data    = {2'b01, 4'b0, 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0};
         end
         cyc();
         in_data_wr = 1'b0;
         if (k == 0) e = w0();
         else if (k == 1) e = w1(exp_upd);
         else if (k == 2) e = w2(exp_seq, t);
         else if (k == 3) e = w3();
         else e = w4();
         chk($sformatf("%s word%0d", tag, k), out_data, e);
         chk($sformatf("%s wr/vwr%0d", tag, k), {out_data_wr, out_data_valid_wr}, {1'b1, k == 4});
      end
      cyc();
      exp_seq = exp_seq + 16'd1;
      chk({tag, " gap wr"}, out_data_wr, 0);
      chk({tag, " gap ready"}, pktin_ready, 1);
      chk({tag, " seq"}, report_seq, exp_seq);
   endtask

   task automatic run_report(input logic exp_upd, input int inj, input string tag);
      sw_trigger = 1'b1;
      cyc();
      sw_trigger = 1'b0;
      cyc();
      chk({tag, " ready low"}, pktin_ready, 0);
      report_body(exp_upd, inj, precision_time, tag);
   endtask

   initial begin
      logic [133:0] pw;
      logic [1:0]   fl;
      int           hdr, nw;

      rst = 1'b1; in_data_wr = 1'b0; in_data = '0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0;
      precision_time = T0; local_mac = MAC; report_en = 1'b1; sw_trigger = 1'b0;
      update_toggle = 1'b0; cnt_in = {C2, C1, C0};
      cyc();
      cyc();
      chk("rst out_data_wr", out_data_wr, 0);
      chk("rst out_data", out_data, 0);
      chk("rst valid/vwr", {out_data_valid, out_data_valid_wr}, 0);
      chk("rst ready", pktin_ready, 1);
      chk("rst counters", {report_seq, overrun_cnt, protocol_err_cnt}, 0);
      rst = 1'b0;
      cyc();

      // Software-triggered report with counters changing after the snapshot.
      tv[0] = '{1'b1, 1'b0, 1'b0, '0,     1'b0, 1'b1};
      tv[1] = '{1'b0, 1'b0, 1'b0, '0,     1'b0, 1'b0};
      tv[2] = '{1'b0, 1'b1, 1'b1, w0(),   1'b0, 1'b0};
      tv[3] = '{1'b0, 1'b1, 1'b1, w1(0),  1'b0, 1'b0};
      tv[4] = '{1'b0, 1'b1, 1'b1, w2(16'd0, T0), 1'b0, 1'b0};
      tv[5] = '{1'b0, 1'b1, 1'b1, w3(),   1'b0, 1'b0};
      tv[6] = '{1'b0, 1'b1, 1'b1, w4(),   1'b1, 1'b0};
      tv[7] = '{1'b0, 1'b0, 1'b0, '0,     1'b0, 1'b1};
      tv[8] = '{1'b0, 1'b0, 1'b0, '0,     1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         sw_trigger = tv[i].sw;
         cnt_in     = tv[i].alt ? ALT : {C2, C1, C0};
         cyc();
         chk($sformatf("tbl%0d wr", i), out_data_wr, tv[i].e_wr);
         chk($sformatf("tbl%0d data", i), out_data, tv[i].e_data);
         chk($sformatf("tbl%0d valid/vwr", i), {out_data_valid, out_data_valid_wr}, {tv[i].e_vwr, tv[i].e_vwr});
         chk($sformatf("tbl%0d ready", i), pktin_ready, tv[i].e_rdy);
      end
      exp_seq = 16'd1;
      chk("tbl seq", report_seq, 16'd1);

      // 8-word packet with a periodic tick at word 3.
      for (int i = 0; i < 8; i++) begin
         fl = (i == 0) ? 2'b01 : (i == 7) ? 2'b10 : 2'b11;
         pw = {fl, 4'b0, 64'hABCD_0000_0000_0000 + 64'(i), ~64'(i)};
         in_data_wr = 1'b1; in_data = pw;
         in_data_valid = (i == 7); in_data_valid_wr = (i == 7);
         precision_time = (i == 3) ? 48'h0000_4000_0000 : (i > 3) ? 48'h0000_4000_0000 + 48'(i) : T0;
         cyc();
         chk($sformatf("pkt word%0d", i), out_data, pw);
         chk($sformatf("pkt wr/vwr%0d", i), {out_data_wr, out_data_valid_wr}, {1'b1, i == 7});
      end
      in_data_wr = 1'b0; in_data_valid = 1'b0; in_data_valid_wr = 1'b0; in_data = '0;
      precision_time = 48'h0000_4000_0123;
      cyc();
      chk("tick start ready", pktin_ready, 0);
      chk("tick start wr", out_data_wr, 0);
      report_body(1'b0, -1, 48'h0000_4000_0123, "tick");

      // Three triggers coalesced while a packet holds off the report.
      precision_time = T0;
      for (int i = 0; i < 5; i++) begin
         in_data_wr = 1'b1;
         fl = (i == 0) ? 2'b01 : (i == 4) ? 2'b10 : 2'b11;
         in_data = {fl, 4'b0, 128'(i)};
         in_data_valid_wr = (i == 4);
         sw_trigger = (i >= 1 && i <= 3);
         cyc();
      end
      in_data_wr = 1'b0; in_data_valid_wr = 1'b0; sw_trigger = 1'b0;
      hdr = 0; nw = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (out_data_wr) nw++;
         if (out_data_wr && out_data[133:132] == 2'b01) hdr++;
      end
      exp_seq = exp_seq + 16'd1;
      chk("ovr count", overrun_cnt, 16'd2);
      chk("ovr reports", 134'(hdr), 134'd1);
      chk("ovr words", 134'(nw), 134'd5);
      chk("ovr seq", report_seq, exp_seq);

      // Update request flag follows the toggle once.
      update_toggle = 1'b1;
      run_report(1'b1, -1, "upd1");
      run_report(1'b0, -1, "upd0");

      // A word driven during a report is dropped.
      run_report(1'b0, 2, "perr");
      chk("perr count", protocol_err_cnt, 16'd1);

      // Disabled triggers, then reset in the middle of a report.
      report_en = 1'b0;
      nw = 0;
      for (int i = 0; i < 12; i++) begin
         precision_time = (i % 2 == 1) ? 48'h0 : 48'h1;
         sw_trigger = (i % 3 == 0);
         cyc();
         if (out_data_wr) nw++;
      end
      sw_trigger = 1'b0; precision_time = T0;
      cyc();
      cyc();
      if (out_data_wr) nw++;
      chk("disabled words", 134'(nw), 134'd0);
      chk("disabled seq", report_seq, exp_seq);
      report_en = 1'b1;
      sw_trigger = 1'b1;
      cyc();
      sw_trigger = 1'b0;
      cyc();
      cyc();
      cyc();
      chk("mid word1", out_data, w1(0));
      rst = 1'b1;
      cyc();
      chk("mrst out", {out_data_wr, out_data_valid, out_data_valid_wr}, 0);
      chk("mrst data", out_data, 0);
      chk("mrst ready", pktin_ready, 1);
      chk("mrst counters", {report_seq, overrun_cnt, protocol_err_cnt}, 0);
      rst = 1'b0;
      nw = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (out_data_wr) nw++;
      end
      chk("post-rst words", 134'(nw), 134'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
